// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM state
// encodings, the undefined-op result value, and opcode class helpers.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_AND    = 5'd3,
    OP_OR     = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  // Result returned for any opcode outside op_e; truncated to XLEN by users.
  localparam logic [63:0] OP_UNDEF_RES = 64'hA;

  function automatic logic is_mul_op(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared one-bit-per-cycle datapath for multiply and divide. Multiply is a
// right-shifting shift-add on magnitudes; divide is a left-shifting restoring
// divide on magnitudes. One adder serves both. The signed fixup and output
// selection are applied to the next-state values, so the final result is
// available combinationally during the last iteration.
module alu_iter_core #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,    // capture operands and mode, clear counter
  input  logic            i_step,    // perform one iteration
  input  logic            i_is_div,  // 1: restoring divide, 0: shift-add multiply
  input  logic            i_neg_q,   // negate product / quotient
  input  logic            i_neg_r,   // negate remainder
  input  logic            i_sel_hi,  // select product high half / remainder
  input  logic [XLEN-1:0] i_a,       // multiplier / dividend magnitude
  input  logic [XLEN-1:0] i_b,       // multiplicand / divisor magnitude
  output logic            o_last,    // this step is the final iteration
  output logic [XLEN-1:0] o_result   // valid while o_last is high
);

  logic [XLEN-1:0]   r_acc;   // partial product high half / partial remainder
  logic [XLEN-1:0]   r_mq;    // multiplier bits / dividend-then-quotient bits
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_sel_hi;

  logic [XLEN+1:0]   w_add_a;
  logic [XLEN+1:0]   w_add_b;
  logic              w_cin;
  logic [XLEN+1:0]   w_sum;
  logic              w_qbit;
  logic [XLEN-1:0]   w_acc_nx;
  logic [XLEN-1:0]   w_mq_nx;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;

  // Shared adder operands: add multiplicand, or subtract divisor from the
  // shifted partial remainder.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_add_a = {2'b00, r_acc};
    w_add_b = r_mq[0] ? {2'b00, r_b} : '0;
    w_cin   = 1'b0;
    if (r_is_div) begin
      w_add_a = {1'b0, r_acc, r_mq[XLEN-1]};
      w_add_b = ~{2'b00, r_b};
      w_cin   = 1'b1;
    end
  end

  assign w_sum  = w_add_a + w_add_b + {{(XLEN+1){1'b0}}, w_cin};
  assign w_qbit = ~w_sum[XLEN+1];

  // Next iteration state for either algorithm.
  always_comb begin
    if (r_is_div) begin
      w_acc_nx = w_qbit ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
      w_mq_nx  = {r_mq[XLEN-2:0], w_qbit};
    end else begin
      w_acc_nx = w_sum[XLEN:1];
      w_mq_nx  = {w_sum[0], r_mq[XLEN-1:1]};
    end
  end

  // Sign fixup and half/quotient/remainder selection on the final values.
  always_comb begin
    w_prod   = {w_acc_nx, w_mq_nx};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo_s  = r_neg_q ? -w_mq_nx : w_mq_nx;
    w_rem_s  = r_neg_r ? -w_acc_nx : w_acc_nx;
    if (r_is_div)
      o_result = r_sel_hi ? w_rem_s : w_quo_s;
    else
      o_result = r_sel_hi ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];
  end

  assign o_last = i_step & (r_cnt == CW'(XLEN-1));

  // Iteration counter; the only core state that must be reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= '0;
    else if (i_step)
      r_cnt <= r_cnt + 1'b1;
  end

  // Datapath registers, loaded on accept and updated each iteration.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are left unreset on purpose; they are always
    // loaded before use, and only control state needs a known reset value.
    if (i_load) begin
      r_acc    <= '0;
      r_mq     <= i_a;
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_neg_q  <= i_neg_q;
      r_neg_r  <= i_neg_r;
      r_sel_hi <= i_sel_hi;
    end else if (i_step) begin
      r_acc <= w_acc_nx;
      r_mq  <= w_mq_nx;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential RV32M/RV64M-style ALU with valid/ready handshakes. Base ops and
// divide corner cases complete in one cycle; multiply and divide run XLEN
// iterations in alu_iter_core. The result is held in DONE until taken.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  op_e             op,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  state_e          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_res;

  logic            w_accept;
  logic            w_take;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_signed_div;
  logic            w_lhs_neg;
  logic            w_rhs_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic            w_load;
  logic            w_step;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_quick_res;
  logic            w_last;
  logic [XLEN-1:0] w_core_res;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_take    = (r_state == DONE) & out_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;

  assign w_is_mul     = is_mul_op(op);
  assign w_is_div     = is_div_op(op);
  assign w_is_rem     = op inside {OP_REM, OP_REMU};
  assign w_signed_div = op inside {OP_DIV, OP_REM};

  // Operand signedness: lhs is signed for MULH/MULHSU/DIV/REM, rhs for
  // MULH/DIV/REM. MUL's low half is sign-independent, so it runs unsigned.
  assign w_lhs_neg = lhs[XLEN-1] & ((op inside {OP_MULH, OP_MULHSU}) | w_signed_div);
  assign w_rhs_neg = rhs[XLEN-1] & ((op == OP_MULH) | w_signed_div);
  assign w_a_mag   = w_lhs_neg ? -lhs : lhs;
  assign w_b_mag   = w_rhs_neg ? -rhs : rhs;

  assign w_div_zero = (rhs == '0);
  assign w_div_ovf  = w_signed_div & (lhs == {1'b1, {(XLEN-1){1'b0}}}) & (&rhs);
  assign w_fast     = w_is_div & (w_div_zero | w_div_ovf);
  assign w_load     = w_accept & (w_is_mul | (w_is_div & ~w_fast));
  assign w_step     = (r_state == MUL) | (r_state == DIV);
  assign w_shamt    = rhs[SHW-1:0];

  // Single-cycle results: base ops, undefined ops and divide corner cases.
  always_comb begin
    w_quick_res = XLEN'(OP_UNDEF_RES);
    case (op)
      OP_ADD:  w_quick_res = lhs + rhs;
      OP_SUB:  w_quick_res = lhs - rhs;
      OP_XOR:  w_quick_res = lhs ^ rhs;
      OP_AND:  w_quick_res = lhs & rhs;
      OP_OR:   w_quick_res = lhs | rhs;
      OP_SLL:  w_quick_res = lhs << w_shamt;
      OP_SRL:  w_quick_res = lhs >> w_shamt;
      OP_SRA:  w_quick_res = $unsigned($signed(lhs) >>> w_shamt);
      OP_SLT:  w_quick_res = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
      OP_SLTU: w_quick_res = {{(XLEN-1){1'b0}}, lhs < rhs};
      default: ;
    endcase
    if (w_is_div) begin
      if (w_div_zero)
        w_quick_res = w_is_rem ? lhs : '1;
      else
        w_quick_res = w_is_rem ? '0 : lhs;
    end
  end

  alu_iter_core #(
    .XLEN (XLEN),
    .CW   (SHW)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_neg_q  (w_lhs_neg ^ w_rhs_neg),
    .i_neg_r  (w_lhs_neg),
    .i_sel_hi (w_is_mul ? (op != OP_MUL) : w_is_rem),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_last   (w_last),
    .o_result (w_core_res)
  );

  // Control FSM with registered out_valid and res; reset wins over handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      unique case (r_state)
        MUL, DIV: begin
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_res       <= w_core_res;
          end
        end
        default: begin
          if (w_take) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_is_mul) begin
              r_state     <= MUL;
              r_out_valid <= 1'b0;
            end else if (w_is_div & ~w_fast) begin
              r_state     <= DIV;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_res       <= w_quick_res;
            end
          end
        end
      endcase
    end
  end

endmodule
